ccff_chain_loader: RTL

Bit-serial configuration-chain loader for the CLB configuration flip-flop (ccff) chain that holds FF MODE_SEL and other fabric configuration bits. It accepts bitstream words from the programming host over a valid/ready handshake and shifts them LSB-first into `ccff_head` while gating `config_enable`. After the load it recirculates the chain once, tail back to head, and compares a CRC-16 of the read-back bits against the CRC of the loaded bits. It sits between the programming interface and the head of the tile-level ccff chain, in the `prog_clk` domain.

---
 rtl/ccff_loader_pkg.sv | 21 ++
 rtl/ccff_crc16_serial.sv | 30 +++
 rtl/ccff_chain_loader.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-16-CCITT helpers for the ccff chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_VERIFY,
        ST_CHECK
    } loader_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One bit-serial CRC step, MSB feedback, no reflection.
    function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT accumulator with synchronous clear (clear beats enable).
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear_i,
    input  logic        enable_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = CRC16_INIT;
        end else if (enable_i) begin
            crc_d = crc16_next(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serial loader for the CLB ccff chain: shifts host words in LSB-first, then
// rotates the chain once and checks a CRC of the read-back against the load.
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 20,
    parameter int WORD_W    = 8
) (
    input  logic                             prog_clk,
    input  logic                             pReset_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [WORD_W-1:0]                word_data,
    input  logic                             word_valid,
    output logic                             word_ready,
    output logic                             ccff_head,
    input  logic                             ccff_tail,
    output logic                             config_enable,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int RES_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  bitCount_q, bitCount_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [RES_W-1:0]  resid_q, resid_d;
    logic              wordReady_q, wordReady_d;
    logic              head_q, head_d;
    logic              cfgEn_q, cfgEn_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              crcClear;
    logic              crcMatch;
    logic [15:0]       loadCrc;
    logic [15:0]       verifyCrc;

    ccff_crc16_serial load_crc (
        .clk      (prog_clk),
        .clear_i  (crcClear || !pReset_n),
        .enable_i ((state_q == ST_LOAD) && (resid_q != '0)),
        .bit_i    (shift_q[0]),
        .crc_o    (loadCrc)
    );

    ccff_crc16_serial verify_crc (
        .clk      (prog_clk),
        .clear_i  (crcClear || !pReset_n),
        .enable_i (state_q == ST_VERIFY),
        .bit_i    (ccff_tail),
        .crc_o    (verifyCrc)
    );

    // The last tail bit is folded in here so done/error can be registered on the final verify edge.
    assign crcMatch = (loadCrc == crc16_next(verifyCrc, ccff_tail));

    always_comb begin
        state_d    = state_q;
        bitCount_d = bitCount_q;
        shift_d    = shift_q;
        resid_d    = resid_q;
        error_d    = error_q;
        done_d     = 1'b0;
        crcClear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    bitCount_d = '0;
                    error_d    = 1'b0;
                    shift_d    = '0;
                    resid_d    = '0;
                    crcClear   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (resid_q != '0) begin
                    shift_d = shift_q >> 1;
                    resid_d = resid_q - RES_W'(1);
                    if (bitCount_q == LAST_CNT) begin
                        // Chain full: drop whatever is left of the final word.
                        state_d    = ST_VERIFY;
                        bitCount_d = '0;
                        resid_d    = '0;
                        shift_d    = '0;
                    end else begin
                        bitCount_d = bitCount_q + CNT_W'(1);
                    end
                end else if (word_valid && wordReady_q) begin
                    shift_d = word_data;
                    resid_d = RES_W'(WORD_W);
                end
            end
            ST_VERIFY: begin
                bitCount_d = bitCount_q + CNT_W'(1);
                if (bitCount_q == LAST_CNT) begin
                    state_d = ST_CHECK;
                    done_d  = crcMatch;
                    error_d = error_q | !crcMatch;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d  = ST_IDLE;
            shift_d  = '0;
            resid_d  = '0;
            error_d  = error_q;
            done_d   = 1'b0;
            crcClear = 1'b0;
        end

        // Outputs are registered, so they are derived from the next state.
        busy_d      = (state_d == ST_LOAD) || (state_d == ST_VERIFY);
        cfgEn_d     = ((state_d == ST_LOAD) && (resid_d != '0)) || (state_d == ST_VERIFY);
        head_d      = (state_d == ST_LOAD) && (resid_d != '0) && shift_d[0];
        wordReady_d = (state_d == ST_LOAD) && (resid_d == '0) && (bitCount_d < LEN_CNT);
    end

    always_ff @(posedge prog_clk) begin
        if (!pReset_n) begin
            state_q     <= ST_IDLE;
            bitCount_q  <= '0;
            shift_q     <= '0;
            resid_q     <= '0;
            wordReady_q <= 1'b0;
            head_q      <= 1'b0;
            cfgEn_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCount_q  <= bitCount_d;
            shift_q     <= shift_d;
            resid_q     <= resid_d;
            wordReady_q <= wordReady_d;
            head_q      <= head_d;
            cfgEn_q     <= cfgEn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // During the read-back rotation the tail is looped straight to the head.
    assign ccff_head     = (state_q == ST_VERIFY) ? ccff_tail : head_q;
    assign word_ready    = wordReady_q;
    assign config_enable = cfgEn_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign bit_count     = bitCount_q;

endmodule
